dcache_controller: RTL and testbench

Data-cache controller between the CPU MEM stage and the 256-bit line-based data memory. It is a 2-way set-associative, write-back, write-allocate cache with 16 sets, 32-byte lines and 1-bit LRU per set. It stalls the pipeline on a miss and runs the memory handshake for write-back and refill. The instance name in the CPU is `dcache`. Internal storage is the submodule instance `dcache_sram`, with arrays `tag[set][way]` (25 bits: {valid, dirty, tag[22:0]}) and `data[set][way]` (256 bits). The signals `state` (IDLE encoded 0) and `sram_dirty` (victim dirty) are named exactly so for bench probing.

---
 rtl/dcache_controller_if.sv | 30 +++
 rtl/dcache_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_dcache_controller.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus of the data cache controller.
// slave: the cache controller itself. master: the CPU/memory side driving it.
interface dcache_controller_if;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  mem_ack_i, mem_data_i,
    output cpu_data_o, cpu_stall_o,
    output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output mem_ack_i, mem_data_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_controller.sv
// 2-way set-associative write-back / write-allocate data cache.
// 16 sets x 2 ways x 256-bit lines, 1-bit LRU per set.
// Address split: offset [4:0], index [8:5], tag [31:9].

// Tag/data/LRU storage. Tag entry = {valid, dirty, tag[22:0]}.
// Data lines are not reset; only valid/dirty/LRU matter after reset.
module dcache_sram (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [3:0]   i_index,
  input  logic [1:0]   i_we,
  input  logic [24:0]  i_tag,
  input  logic [255:0] i_data,
  input  logic         i_lru_we,
  input  logic         i_lru,
  output logic [24:0]  o_tag0,
  output logic [24:0]  o_tag1,
  output logic [255:0] o_data0,
  output logic [255:0] o_data1,
  output logic         o_lru
);
  logic [24:0]  tag  [16][2];
  logic [255:0] data [16][2];
  logic [15:0]  r_lru;

  // Tag and LRU bits: cleared by reset, written per way on hit-store or refill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < 16; s++) begin
        tag[s][0] <= '0;
        tag[s][1] <= '0;
      end
      r_lru <= '0;
    end else begin
      if (i_we[0]) tag[i_index][0] <= i_tag;
      if (i_we[1]) tag[i_index][1] <= i_tag;
      if (i_lru_we) r_lru[i_index] <= i_lru;
    end
  end

  // Line data: plain write port, no reset.
  always_ff @(posedge clk_i) begin
    if (i_we[0]) data[i_index][0] <= i_data;
    if (i_we[1]) data[i_index][1] <= i_data;
  end

  assign o_tag0  = tag[i_index][0];
  assign o_tag1  = tag[i_index][1];
  assign o_data0 = data[i_index][0];
  assign o_data1 = data[i_index][1];
  assign o_lru   = r_lru[i_index];
endmodule

module dcache_controller (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dcache_controller_if.slave   bus
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    READMISS   = 3'd3,
    READMISSOK = 3'd4
  } state_t;

  state_t        state, w_next_state;
  logic          r_mem_enable, w_mem_enable;
  logic          r_mem_write, w_mem_write;
  logic [31:0]   r_mem_addr, w_mem_addr;
  logic [255:0]  r_mem_data, w_mem_data;
  logic [255:0]  r_refill_line;

  logic          w_req, w_wr;
  logic [3:0]    w_index;
  logic [22:0]   w_tag;
  logic [2:0]    w_word;
  logic [24:0]   w_tag0, w_tag1, w_victim_tag;
  logic [255:0]  w_data0, w_data1, w_hit_line, w_victim_line, w_merged;
  logic          w_lru, w_hit0, w_hit1, w_hit, w_victim, sram_dirty, w_refill;
  logic [1:0]    w_sram_we;
  logic [24:0]   w_sram_tag;
  logic [255:0]  w_sram_data;
  logic          w_lru_we, w_lru_val;
  logic          w_unused;

  assign w_req   = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign w_wr    = bus.cpu_MemWrite_i;
  assign w_index = bus.cpu_addr_i[8:5];
  assign w_tag   = bus.cpu_addr_i[31:9];
  assign w_word  = bus.cpu_addr_i[4:2];
  assign w_unused = &{1'b0, bus.cpu_addr_i[1:0]};

  dcache_sram dcache_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_index  (w_index),
    .i_we     (w_sram_we),
    .i_tag    (w_sram_tag),
    .i_data   (w_sram_data),
    .i_lru_we (w_lru_we),
    .i_lru    (w_lru_val),
    .o_tag0   (w_tag0),
    .o_tag1   (w_tag1),
    .o_data0  (w_data0),
    .o_data1  (w_data1),
    .o_lru    (w_lru)
  );

  assign w_hit0 = w_tag0[24] & (w_tag0[22:0] == w_tag);
  assign w_hit1 = w_tag1[24] & (w_tag1[22:0] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;
  assign w_hit_line = w_hit1 ? w_data1 : w_data0;

  // Invalid ways are filled first (way 0 preferred); otherwise LRU names the victim.
  assign w_victim      = ~w_tag0[24] ? 1'b0 : (~w_tag1[24] ? 1'b1 : w_lru);
  assign w_victim_tag  = w_victim ? w_tag1 : w_tag0;
  assign w_victim_line = w_victim ? w_data1 : w_data0;
  assign sram_dirty    = w_victim_tag[24] & w_victim_tag[23];

  // The refill line is written one cycle after the ack, so the line starts hitting in IDLE.
  assign w_refill = (state == READMISSOK);

  assign bus.cpu_stall_o  = w_req & ~w_hit;
  assign bus.cpu_data_o   = w_hit ? w_hit_line[{w_word, 5'b0} +: 32] : 32'd0;
  assign bus.mem_enable_o = r_mem_enable;
  assign bus.mem_write_o  = r_mem_write;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_data_o   = r_mem_data;

  // Store data merged into the hit line.
  always_comb begin
    w_merged = w_hit_line;
    w_merged[{w_word, 5'b0} +: 32] = bus.cpu_data_i;
  end

  // Array write port: refill of the victim way, or store hit; LRU points away from the touched way.
  always_comb begin
    w_sram_we   = 2'b00;
    w_sram_tag  = {1'b1, 1'b1, w_tag};
    w_sram_data = w_merged;
    w_lru_we    = 1'b0;
    w_lru_val   = 1'b0;
    if (w_refill) begin
      w_sram_we[w_victim] = 1'b1;
      w_sram_tag  = {1'b1, 1'b0, w_tag};
      w_sram_data = r_refill_line;
      w_lru_we    = 1'b1;
      w_lru_val   = ~w_victim;
    end else if (w_req && w_hit) begin
      w_lru_we  = 1'b1;
      w_lru_val = ~w_hit1;
      if (w_wr) w_sram_we[w_hit1] = 1'b1;
    end
  end

  // State and registered memory-request outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      state        <= w_next_state;
      r_mem_enable <= w_mem_enable;
      r_mem_write  <= w_mem_write;
      r_mem_addr   <= w_mem_addr;
      r_mem_data   <= w_mem_data;
    end
  end

  // Refill line capture at the read ack.
  always_ff @(posedge clk_i) begin
    if (state == READMISS && bus.mem_ack_i) r_refill_line <= bus.mem_data_i;
  end

  // Next state and next memory-request values; outputs hold unless changed here.
  always_comb begin
    w_next_state = state;
    w_mem_enable = r_mem_enable;
    w_mem_write  = r_mem_write;
    w_mem_addr   = r_mem_addr;
    w_mem_data   = r_mem_data;
    unique case (state)
      IDLE: begin
        if (w_req && !w_hit) w_next_state = MISS;
      end
      MISS: begin
        w_mem_enable = 1'b1;
        if (sram_dirty) begin
          w_mem_write  = 1'b1;
          w_mem_addr   = {w_victim_tag[22:0], w_index, 5'b0};
          w_mem_data   = w_victim_line;
          w_next_state = WRITEBACK;
        end else begin
          w_mem_write  = 1'b0;
          w_mem_addr   = {bus.cpu_addr_i[31:5], 5'b0};
          w_next_state = READMISS;
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          w_mem_write  = 1'b0;
          w_mem_addr   = {bus.cpu_addr_i[31:5], 5'b0};
          w_next_state = READMISS;
        end
      end
      READMISS: begin
        if (bus.mem_ack_i) begin
          w_mem_enable = 1'b0;
          w_next_state = READMISSOK;
        end
      end
      READMISSOK: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: vector table of CPU accesses with a stall/data
// scoreboard, a memory responder checking expected line transactions, and
// hand-written spurious-ack and reset-during-writeback sequences.
module tb_dcache_controller;
  localparam int LAT = 2;
  localparam logic [255:0] LINE0 =
    256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;

  logic clk_i = 1'b0;
  logic rst_i;

  dcache_controller_if bus();

  dcache_controller dcache (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  typedef struct {
    string       name;
    logic        chk_data;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  typedef struct {
    string        name;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         rd;
    logic         wr;
    logic [31:0]  exp_rdata;
    int           exp_stall;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    logic         rf;
    logic [31:0]  rf_addr;
  } vec_t;

  txn_t mem_q[$];
  exp_t sb_q[$];
  vec_t vecs[$];

  int n_cmp = 0;
  int n_err = 0;
  bit hold = 1'b0;
  int spur_req = 0;

  function automatic logic [255:0] make_line(int l);
    logic [255:0] v;
    v = '0;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = 32'hA000_0000 | 32'(l << 8) | 32'(w);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr, input logic [31:0] er, input int es,
                         input logic wb, input logic [31:0] wba, input logic [255:0] wbl,
                         input logic rf, input logic [31:0] rfa);
    vec_t v;
    v.name = nm; v.addr = a; v.wdata = wd; v.rd = rd; v.wr = wr;
    v.exp_rdata = er; v.exp_stall = es;
    v.wb = wb; v.wb_addr = wba; v.wb_line = wbl; v.rf = rf; v.rf_addr = rfa;
    vecs.push_back(v);
  endtask

  task automatic push_txn(input logic we, input logic [31:0] a, input logic [255:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    mem_q.push_back(t);
  endtask

  // One CPU access: drive, count stalled cycles, compare against the scoreboard entry.
  task automatic access(input string nm, input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, input logic [31:0] er, input int es);
    exp_t e;
    int   cyc;
    e.name = nm; e.chk_data = rd & ~wr; e.rdata = er; e.stall = es;
    sb_q.push_back(e);
    @(negedge clk_i);
    bus.cpu_addr_i     = a;
    bus.cpu_data_i     = wd;
    bus.cpu_MemRead_i  = rd;
    bus.cpu_MemWrite_i = wr;
    #1;
    cyc = 0;
    while (bus.cpu_stall_o !== 1'b0 && cyc < 100) begin
      cyc++;
      @(negedge clk_i);
      #1;
    end
    e = sb_q.pop_front();
    chk({e.name, " stall"}, 256'(cyc), 256'(e.stall));
    if (e.chk_data) chk({e.name, " rdata"}, 256'(bus.cpu_data_o), 256'(e.rdata));
    @(negedge clk_i);
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
  endtask

  // Memory model: sees a request at the negedge after mem_enable_o rises,
  // acks LAT cycles later, commits writes / supplies lines at the ack.
  initial begin : responder
    logic [255:0] mem [64];
    bit   busy;
    int   cnt;
    int   spur_seen;
    txn_t cur;
    txn_t e;
    for (int i = 0; i < 64; i++) mem[i] = make_line(i);
    mem[0] = LINE0;
    mem[32][31:0] = 32'hE00EF00F;
    busy = 1'b0; cnt = 0; spur_seen = 0;
    cur.we = 1'b0; cur.addr = '0; cur.data = '0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      bus.mem_ack_i = 1'b0;
      if (rst_i !== 1'b0) begin
        busy = 1'b0;
      end else if (spur_seen != spur_req) begin
        spur_seen = spur_req;
        bus.mem_data_i = {8{32'hBAD0BAD0}};
        bus.mem_ack_i  = 1'b1;
      end else begin
        if (!busy && bus.mem_enable_o === 1'b1) begin
          cur.we = bus.mem_write_o; cur.addr = bus.mem_addr_o; cur.data = bus.mem_data_o;
          busy = 1'b1;
          cnt  = LAT;
          if (mem_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mem txn: unexpected request we=%0b addr=%h", cur.we, cur.addr);
          end else begin
            e = mem_q.pop_front();
            chk("mem we", 256'(cur.we), 256'(e.we));
            chk("mem addr", 256'(cur.addr), 256'(e.addr));
            if (e.we) chk("mem wb line", cur.data, e.data);
          end
        end
        if (busy && !hold) begin
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            if (cur.we) mem[cur.addr[10:5]] = cur.data;
            else        bus.mem_data_i = mem[cur.addr[10:5]];
            bus.mem_ack_i = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [255:0] l0_deadbeef;
    logic [255:0] l0_final;
    int k;

    rst_i = 1'b1;
    bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
    bus.cpu_MemRead_i = 1'b0; bus.cpu_MemWrite_i = 1'b0;
    #2;
    chk("reset state", 256'(dcache.state), 256'(0));
    chk("reset mem_enable", 256'(bus.mem_enable_o), 256'(0));
    chk("reset mem_write", 256'(bus.mem_write_o), 256'(0));
    chk("reset mem_addr", 256'(bus.mem_addr_o), 256'(0));
    chk("reset mem_data", bus.mem_data_o, 256'(0));
    chk("reset stall idle", 256'(bus.cpu_stall_o), 256'(0));
    bus.cpu_MemRead_i = 1'b1;
    #1;
    chk("reset stall on req", 256'(bus.cpu_stall_o), 256'(1));
    bus.cpu_MemRead_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b0;

    l0_deadbeef = LINE0;
    l0_deadbeef[31:0] = 32'hDEADBEEF;
    l0_final = LINE0;
    l0_final[31:0]  = 32'h11112222;
    l0_final[63:32] = 32'h55556666;

    //       name               addr       wdata         rd    wr    rdata         stall wb  wb_addr  wb_line      rf  rf_addr
    add_vec("cold rd 0x0",    32'h0,   32'h0,        1'b1, 1'b0, 32'hEEEEFFFF, 5, 1'b0, 32'h0, '0,          1'b1, 32'h0);
    add_vec("hit rd 0x4",     32'h4,   32'h0,        1'b1, 1'b0, 32'hCCCCDDDD, 0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("alloc wr 0x20",  32'h20,  32'h12345678, 1'b0, 1'b1, 32'h0,        5, 1'b0, 32'h0, '0,          1'b1, 32'h20);
    add_vec("hit rd 0x20",    32'h20,  32'h0,        1'b1, 1'b0, 32'h12345678, 0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("hit wr 0x0",     32'h0,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("miss rd 0x200",  32'h200, 32'h0,        1'b1, 1'b0, 32'hA0001000, 5, 1'b0, 32'h0, '0,          1'b1, 32'h200);
    add_vec("dirty ev 0x400", 32'h400, 32'h0,        1'b1, 1'b0, 32'hE00EF00F, 7, 1'b1, 32'h0, l0_deadbeef, 1'b1, 32'h400);
    add_vec("refetch 0x0",    32'h0,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 5, 1'b0, 32'h0, '0,          1'b1, 32'h0);
    add_vec("clean rd 0x200", 32'h200, 32'h0,        1'b1, 1'b0, 32'hA0001000, 5, 1'b0, 32'h0, '0,          1'b1, 32'h200);
    add_vec("hit rd 0x0 b",   32'h0,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("clean ev 0x400", 32'h400, 32'h0,        1'b1, 1'b0, 32'hE00EF00F, 5, 1'b0, 32'h0, '0,          1'b1, 32'h400);
    add_vec("keep 0x0",       32'h0,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("hit rd 0x24",    32'h24,  32'h0,        1'b1, 1'b0, 32'hA0000101, 0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("rd+wr 0x4",      32'h4,   32'h55556666, 1'b1, 1'b1, 32'h0,        0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("hit rd 0x4 b",   32'h4,   32'h0,        1'b1, 1'b0, 32'h55556666, 0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("hit wr 0x0 b",   32'h0,   32'h11112222, 1'b0, 1'b1, 32'h0,        0, 1'b0, 32'h0, '0,          1'b0, 32'h0);
    add_vec("hit rd 0x400",   32'h400, 32'h0,        1'b1, 1'b0, 32'hE00EF00F, 0, 1'b0, 32'h0, '0,          1'b0, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].wb) push_txn(1'b1, vecs[i].wb_addr, vecs[i].wb_line);
      if (vecs[i].rf) push_txn(1'b0, vecs[i].rf_addr, '0);
      access(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr,
             vecs[i].exp_rdata, vecs[i].exp_stall);
    end

    chk("set1 way0 dirty tag", 256'(dcache.dcache_sram.tag[1][0]), 256'({2'b11, 23'h0}));

    // Spurious ack in IDLE must not move the FSM or touch the arrays.
    @(negedge clk_i);
    spur_req++;
    repeat (3) @(negedge clk_i);
    #1;
    chk("spurious state", 256'(dcache.state), 256'(0));
    chk("spurious tag0", 256'(dcache.dcache_sram.tag[0][0]), 256'({2'b10, 23'h2}));
    chk("spurious tag1", 256'(dcache.dcache_sram.tag[0][1]), 256'({2'b11, 23'h0}));
    chk("spurious data", 256'(dcache.dcache_sram.data[0][1][31:0]), 256'(32'h11112222));
    chk("spurious lru", 256'(dcache.dcache_sram.r_lru[0]), 256'(1));
    chk("spurious enable", 256'(bus.mem_enable_o), 256'(0));

    // Reset while the dirty 0x0 line is being written back.
    push_txn(1'b1, 32'h0, l0_final);
    hold = 1'b1;
    @(negedge clk_i);
    bus.cpu_addr_i = 32'h200;
    bus.cpu_MemRead_i = 1'b1;
    k = 0;
    while (dcache.state != 3'd2 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("reach WRITEBACK", 256'(dcache.state), 256'(2));
    chk("wb enable", 256'(bus.mem_enable_o), 256'(1));
    #2 rst_i = 1'b1;
    #1;
    chk("async rst state", 256'(dcache.state), 256'(0));
    chk("async rst enable", 256'(bus.mem_enable_o), 256'(0));
    chk("async rst write", 256'(bus.mem_write_o), 256'(0));
    chk("async rst valid", 256'(dcache.dcache_sram.tag[0][1][24]), 256'(0));
    chk("async rst stall", 256'(bus.cpu_stall_o), 256'(1));
    @(negedge clk_i);
    bus.cpu_MemRead_i = 1'b0;
    hold = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b0;

    push_txn(1'b0, 32'h0, '0);
    access("post-reset 0x0", 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 5);

    repeat (4) @(negedge clk_i);
    chk("mem queue drained", 256'(mem_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
